// File: rtl/host_loader_if.sv
// Host byte port and memory write port of the host loader.
// The host side (master) drives the byte stream and hold.
// The loader side (slave) drives the handshake ready signal, the write strobes and the status outputs.
interface host_loader_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
);
    logic              hold;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              wr_en_imem;
    logic              wr_en_wmem;
    logic              wr_en_ub;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output hold, in_valid, in_data,
        input  in_ready, wr_en_imem, wr_en_wmem, wr_en_ub,
        input  wr_addr, wr_data, busy, done, err
    );

    modport slave (
        input  hold, in_valid, in_data,
        output in_ready, wr_en_imem, wr_en_wmem, wr_en_ub,
        output wr_addr, wr_data, busy, done, err
    );
endinterface

// File: rtl/host_loader.sv
// Host loader: decodes HDR/ALO/LEN packet headers from a host byte stream.
// For each payload byte it issues one registered write strobe to the
// instruction memory, the weight memory or the unified buffer.
// A packet with the reserved target is consumed in full without writing anything and ends with an err pulse.
module host_loader #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input  logic         clk,
    input  logic         reset,
    host_loader_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_LEN  = 2'd2,
        ST_DATA = 2'd3
    } state_t;

    localparam logic [1:0] TGT_IMEM = 2'b00;
    localparam logic [1:0] TGT_WMEM = 2'b01;
    localparam logic [1:0] TGT_UB   = 2'b10;

    state_t            state_r;
    logic [1:0]        tgt_r;
    logic [4:0]        addr_hi_r;
    logic [ADDR_W-1:0] addr_r;
    logic [7:0]        count_r;
    logic              wr_en_imem_r;
    logic              wr_en_wmem_r;
    logic              wr_en_ub_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [DATA_W-1:0] wr_data_r;
    logic              done_r;
    logic              err_r;
    logic              accept_s;

    // Ready depends only on hold and reset, never on in_valid.
    assign bus.in_ready = !reset && !bus.hold;
    assign accept_s     = bus.in_valid && bus.in_ready;

    assign bus.wr_en_imem = wr_en_imem_r;
    assign bus.wr_en_wmem = wr_en_wmem_r;
    assign bus.wr_en_ub   = wr_en_ub_r;
    assign bus.wr_addr    = wr_addr_r;
    assign bus.wr_data    = wr_data_r;
    assign bus.busy       = (state_r != ST_IDLE);
    assign bus.done       = done_r;
    assign bus.err        = err_r;

    // Packet FSM. Strobes and pulses default low each cycle and rise only in the cycle after a DATA accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            tgt_r        <= 2'b00;
            addr_hi_r    <= 5'd0;
            addr_r       <= '0;
            count_r      <= 8'd0;
            wr_en_imem_r <= 1'b0;
            wr_en_wmem_r <= 1'b0;
            wr_en_ub_r   <= 1'b0;
            wr_addr_r    <= '0;
            wr_data_r    <= '0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            wr_en_imem_r <= 1'b0;
            wr_en_wmem_r <= 1'b0;
            wr_en_ub_r   <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            if (accept_s) begin
                case (state_r)
                    ST_IDLE: begin
                        // HDR[5] carries no meaning and is dropped.
                        tgt_r     <= bus.in_data[7:6];
                        addr_hi_r <= bus.in_data[4:0];
                        state_r   <= ST_ADDR;
                    end
                    ST_ADDR: begin
                        addr_r  <= ADDR_W'({addr_hi_r, bus.in_data[7:0]});
                        state_r <= ST_LEN;
                    end
                    ST_LEN: begin
                        count_r <= bus.in_data[7:0];
                        state_r <= ST_DATA;
                    end
                    ST_DATA: begin
                        wr_addr_r    <= addr_r;
                        wr_data_r    <= bus.in_data;
                        wr_en_imem_r <= (tgt_r == TGT_IMEM);
                        wr_en_wmem_r <= (tgt_r == TGT_WMEM);
                        wr_en_ub_r   <= (tgt_r == TGT_UB);
                        // The address wraps silently at the top of memory.
                        addr_r       <= addr_r + ADDR_W'(1);
                        count_r      <= count_r - 8'd1;
                        if (count_r == 8'd0) begin
                            state_r <= ST_IDLE;
                            if (tgt_r == 2'b11) begin
                                err_r <= 1'b1;
                            end else begin
                                done_r <= 1'b1;
                            end
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end
endmodule

// File: tb/tb_host_loader.sv
// Self-checking bench for host_loader.
// Expected write/done/err events are queued as bytes are accepted.
// They are popped and compared whenever the loader produces an event.
module tb_host_loader;
    logic clk;
    logic reset;

    host_loader_if #(.ADDR_W(13), .DATA_W(8)) ifc ();

    host_loader #(.ADDR_W(13), .DATA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    int errs   = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    // Queue entry: {imem, wmem, ub, done, err, addr[12:0], data[7:0]}
    logic [25:0] exp_q[$];
    logic [7:0]  pkt_data[256];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare each observed event with the oldest expected one.
    always @(negedge clk) begin
        logic [4:0]  flags;
        logic [25:0] e;
        if (mon_en) begin
            flags = {ifc.wr_en_imem, ifc.wr_en_wmem, ifc.wr_en_ub, ifc.done, ifc.err};
            if (flags != 5'd0) begin
                check_eq("strobe_onehot", 32'($countones(flags[4:2]) <= 1), 32'd1);
                check_eq("done_err_excl", 32'(flags[1] && flags[0]), 32'd0);
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_event", 32'(flags), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("event_flags", 32'(flags), 32'(e[25:21]));
                    if (!e[21]) begin
                        check_eq("wr_addr", 32'(ifc.wr_addr), 32'(e[20:8]));
                        check_eq("wr_data", 32'(ifc.wr_data), 32'(e[7:0]));
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        ifc.in_valid = 1'b1;
        ifc.in_data  = b;
        n = 0;
        @(posedge clk);
        while (!ifc.in_ready && n < 64) begin
            n++;
            @(posedge clk);
        end
        if (n >= 64) check_eq("accept_timeout", 32'd0, 32'd1);
        #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        ifc.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_hold();
        ifc.hold = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ifc.in_valid = k[0];
            ifc.in_data  = 8'hEE;
            @(negedge clk);
            check_eq("ready_in_hold", 32'(ifc.in_ready), 32'd0);
            check_eq("busy_in_hold", 32'(ifc.busy), 32'd1);
            @(posedge clk);
            #1;
        end
        ifc.in_valid = 1'b0;
        ifc.hold     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        check_eq("ready_in_reset", 32'(ifc.in_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("busy_after_reset", 32'(ifc.busy), 32'd0);
        check_eq("done_after_reset", 32'(ifc.done), 32'd0);
        check_eq("strobes_after_reset", 32'({ifc.wr_en_imem, ifc.wr_en_wmem, ifc.wr_en_ub}), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] alo, input logic [7:0] len,
                            input int stall_at, input int reset_at, input bit gaps);
        logic [1:0]  tgt;
        logic [12:0] a;
        logic [4:0]  fl;
        bit          last;
        tgt = hdr[7:6];
        a   = {hdr[4:0], alo};
        send_byte(hdr);
        send_byte(alo);
        send_byte(len);
        check_eq("busy_in_pkt", 32'(ifc.busy), 32'd1);
        for (int i = 0; i <= int'(len); i++) begin
            if (i == stall_at) do_hold();
            if (gaps && i[0]) idle_cycle();
            send_byte(pkt_data[i]);
            last = (i == int'(len));
            case (tgt)
                2'b00:   fl = {3'b100, last, 1'b0};
                2'b01:   fl = {3'b010, last, 1'b0};
                2'b10:   fl = {3'b001, last, 1'b0};
                default: fl = last ? 5'b00001 : 5'b00000;
            endcase
            if (fl != 5'd0) exp_q.push_back({fl, a, pkt_data[i]});
            a = a + 13'd1;
            if (i == reset_at) begin
                do_reset();
                return;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("busy_idle", 32'(ifc.busy), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        ifc.hold     = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", 32'(ifc.in_ready), 32'd0);
        check_eq("rst_wr_addr", 32'(ifc.wr_addr), 32'd0);
        check_eq("rst_wr_data", 32'(ifc.wr_data), 32'd0);
        check_eq("rst_flags", 32'({ifc.wr_en_imem, ifc.wr_en_wmem, ifc.wr_en_ub,
                                   ifc.busy, ifc.done, ifc.err}), 32'd0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check_eq("ready_after_rst", 32'(ifc.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // 1: wmem @0x0000, 4 bytes
        pkt_data[0] = 8'h11; pkt_data[1] = 8'h22; pkt_data[2] = 8'h33; pkt_data[3] = 8'h44;
        send_pkt(8'h40, 8'h00, 8'h03, -1, -1, 1'b0);
        drain();

        // 2: ub @0x1FFF, 2 bytes, address wraps
        pkt_data[0] = 8'hAA; pkt_data[1] = 8'hBB;
        send_pkt(8'h9F, 8'hFF, 8'h01, -1, -1, 1'b0);
        drain();

        // 3: reserved target, then an imem packet right behind it
        pkt_data[0] = 8'h55; pkt_data[1] = 8'h66;
        send_pkt(8'hC0, 8'h10, 8'h01, -1, -1, 1'b0);
        pkt_data[0] = 8'h7E;
        send_pkt(8'h00, 8'h00, 8'h00, -1, -1, 1'b0);
        drain();

        // 4: ub @0x0020, 8 bytes, with valid gaps and a 5-cycle hold mid-DATA
        for (int i = 0; i < 8; i++) pkt_data[i] = 8'($urandom_range(0, 255));
        send_pkt(8'hA0, 8'h20, 8'h07, 3, -1, 1'b1);
        drain();

        // 5: reset after the 2nd data byte, then a fresh one-byte packet
        pkt_data[0] = 8'h01; pkt_data[1] = 8'h02; pkt_data[2] = 8'h03; pkt_data[3] = 8'h04;
        send_pkt(8'h40, 8'h00, 8'h03, -1, 1, 1'b0);
        drain();
        pkt_data[0] = 8'h99;
        send_pkt(8'h40, 8'h08, 8'h00, -1, -1, 1'b0);
        drain();

        // 6: 256 bytes to imem @0x0100
        for (int i = 0; i < 256; i++) pkt_data[i] = 8'(i ^ 8'h5A);
        send_pkt(8'h01, 8'h00, 8'hFF, -1, -1, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
